// File: rtl/next_pc_pkg.sv
// Shared encodings and constants for the next-PC generator.
package next_pc_pkg;

    // Next-PC source select.
    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // Branch condition select; codes 6 and 7 never take.
    localparam logic [2:0] BR_EQ = 3'd0;
    localparam logic [2:0] BR_NE = 3'd1;
    localparam logic [2:0] BR_LT = 3'd2;
    localparam logic [2:0] BR_GT = 3'd3;
    localparam logic [2:0] BR_LE = 3'd4;
    localparam logic [2:0] BR_GE = 3'd5;

    // Fetch-unit reset PC.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/next_pc_if.sv
// Fetch-side bus for the next-PC generator: decoded control and flags in,
// targets and trace status out.
interface next_pc_if;
    logic [31:0] PC;
    logic [1:0]  NPCop;
    logic [2:0]  Branchop;
    logic [25:0] instr_index;
    logic [15:0] offset;
    logic [31:0] Reg;
    logic        equal;
    logic        n_equal;
    logic        less;
    logic        big;
    logic        less_or_equal;
    logic        big_or_equal;
    logic [31:0] NPC;
    logic [31:0] PC4;
    logic        taken;
    logic        taken_q;
    logic [31:0] last_target_q;

    // Fetch/decode side drives control and consumes targets.
    modport master (
        output PC, NPCop, Branchop, instr_index, offset, Reg,
               equal, n_equal, less, big, less_or_equal, big_or_equal,
        input  NPC, PC4, taken, taken_q, last_target_q
    );

    // Next-PC block.
    modport slave (
        input  PC, NPCop, Branchop, instr_index, offset, Reg,
               equal, n_equal, less, big, less_or_equal, big_or_equal,
        output NPC, PC4, taken, taken_q, last_target_q
    );
endinterface

// File: rtl/next_pc_branch_cond.sv
// Branch condition mux: picks one comparator flag by Branchop.
module next_pc_branch_cond
    import next_pc_pkg::*;
(
    input  logic [2:0] Branchop,
    input  logic       equal,
    input  logic       n_equal,
    input  logic       less,
    input  logic       big,
    input  logic       less_or_equal,
    input  logic       big_or_equal,
    output logic       cond
);

    // Flags are trusted as supplied; reserved codes never take.
    always_comb begin
        cond = 1'b0;
        case (Branchop)
            BR_EQ:   cond = equal;
            BR_NE:   cond = n_equal;
            BR_LT:   cond = less;
            BR_GT:   cond = big;
            BR_LE:   cond = less_or_equal;
            BR_GE:   cond = big_or_equal;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_pc.sv
// Next-PC generator for the single-cycle fetch unit (no delay slot).
// Target path is combinational so the PC register loads NPC on the same edge;
// a small registered section records the last redirect for trace.
module next_pc
    import next_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    next_pc_if.slave    bus
);

    logic [31:0] pc4;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        cond;
    logic [31:0] npc;
    logic        tkn;

    logic        taken_r;
    logic [31:0] last_target_r;

    next_pc_branch_cond u_cond (
        .Branchop      (bus.Branchop),
        .equal         (bus.equal),
        .n_equal       (bus.n_equal),
        .less          (bus.less),
        .big           (bus.big),
        .less_or_equal (bus.less_or_equal),
        .big_or_equal  (bus.big_or_equal),
        .cond          (cond)
    );

    // Target adders; jump region comes from PC itself, not PC+4.
    always_comb begin
        pc4 = bus.PC + 32'd4;
        bt  = pc4 + {{14{bus.offset[15]}}, bus.offset, 2'b00};
        jt  = {bus.PC[31:28], bus.instr_index, 2'b00};
    end

    // Source select; Branchop only matters for conditional branches.
    always_comb begin
        npc = pc4;
        tkn = 1'b0;
        case (bus.NPCop)
            NPC_SEQ: begin
                npc = pc4;
                tkn = 1'b0;
            end
            NPC_BR: begin
                npc = cond ? bt : pc4;
                tkn = cond;
            end
            NPC_J: begin
                npc = jt;
                tkn = 1'b1;
            end
            NPC_JR: begin
                npc = bus.Reg;
                tkn = 1'b1;
            end
            default: begin
                npc = pc4;
                tkn = 1'b0;
            end
        endcase
    end

    // Trace status of the redirect taken at the last edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_r       <= 1'b0;
            last_target_r <= RESET_PC;
        end else begin
            taken_r       <= tkn;
            last_target_r <= npc;
        end
    end

    assign bus.NPC           = npc;
    assign bus.PC4           = pc4;
    assign bus.taken         = tkn;
    assign bus.taken_q       = taken_r;
    assign bus.last_target_q = last_target_r;

endmodule

// File: tb/tb_next_pc.sv
// Directed-vector bench for next_pc with hand-computed expectations.
module tb_next_pc;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    next_pc_if bus ();

    next_pc #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // flags = {big_or_equal, less_or_equal, big, less, n_equal, equal}
    task automatic drive(input logic [31:0] pc, input logic [1:0] op, input logic [2:0] bop,
                         input logic [25:0] idx, input logic [15:0] off,
                         input logic [31:0] rg, input logic [5:0] flags);
        @(negedge clk);
        bus.PC = pc; bus.NPCop = op; bus.Branchop = bop;
        bus.instr_index = idx; bus.offset = off; bus.Reg = rg;
        bus.equal = flags[0]; bus.n_equal = flags[1]; bus.less = flags[2];
        bus.big = flags[3]; bus.less_or_equal = flags[4]; bus.big_or_equal = flags[5];
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(32'h3000, 2'd0, 3'd0, 26'd0, 16'd0, 32'd0, 6'd0);
        @(posedge clk); #1;
        chk("rst_taken_q", {31'd0, bus.taken_q}, 32'd0);
        chk("rst_last", bus.last_target_q, 32'h3000);
        reset = 1'b0;

        // Sequential
        drive(32'h3000, 2'd0, 3'd0, 26'd0, 16'd0, 32'd0, 6'd0);
        chk("seq_npc", bus.NPC, 32'h3004);
        chk("seq_pc4", bus.PC4, 32'h3004);
        chk("seq_taken", {31'd0, bus.taken}, 32'd0);

        // Backward beq, taken and not taken
        drive(32'h3008, 2'd1, 3'd0, 26'd0, 16'hFFFE, 32'd0, 6'b000001);
        chk("beq_t_npc", bus.NPC, 32'h3004);
        chk("beq_t_taken", {31'd0, bus.taken}, 32'd1);
        drive(32'h3008, 2'd1, 3'd0, 26'd0, 16'hFFFE, 32'd0, 6'b000000);
        chk("beq_n_npc", bus.NPC, 32'h300C);
        chk("beq_n_taken", {31'd0, bus.taken}, 32'd0);

        // Forward bge and reserved code
        drive(32'h3000, 2'd1, 3'd5, 26'd0, 16'h0003, 32'd0, 6'b100000);
        chk("bge_npc", bus.NPC, 32'h3010);
        drive(32'h3000, 2'd1, 3'd6, 26'd0, 16'h0003, 32'd0, 6'b111111);
        chk("br6_npc", bus.NPC, 32'h3004);
        chk("br6_taken", {31'd0, bus.taken}, 32'd0);
        drive(32'h3000, 2'd1, 3'd7, 26'd0, 16'h0003, 32'd0, 6'b111111);
        chk("br7_npc", bus.NPC, 32'h3004);

        // Each condition code selects exactly its own flag
        for (int b = 0; b < 6; b++) begin
            drive(32'h3000, 2'd1, 3'(b), 26'd0, 16'h0001, 32'd0, 6'(1 << b));
            chk($sformatf("br%0d_own", b), bus.NPC, 32'h3008);
            drive(32'h3000, 2'd1, 3'(b), 26'd0, 16'h0001, 32'd0, ~6'(1 << b));
            chk($sformatf("br%0d_other", b), bus.NPC, 32'h3004);
        end

        // Jumps (Branchop/flags ignored)
        drive(32'h3000, 2'd2, 3'd0, 26'h0000C05, 16'h0001, 32'd0, 6'b111111);
        chk("j_npc", bus.NPC, 32'h0000_3014);
        chk("j_taken", {31'd0, bus.taken}, 32'd1);
        drive(32'h9000_0000, 2'd2, 3'd0, 26'h0000C05, 16'd0, 32'd0, 6'd0);
        chk("j_hi_npc", bus.NPC, 32'h9000_3014);
        chk("j_hi_pc4", bus.PC4, 32'h9000_0004);
        drive(32'h3000, 2'd3, 3'd0, 26'h0000C05, 16'd0, 32'h0000_3101, 6'b000001);
        chk("jr_unaligned", bus.NPC, 32'h0000_3101);
        drive(32'h3000, 2'd3, 3'd0, 26'd0, 16'd0, 32'h0000_3100, 6'd0);
        chk("jr_npc", bus.NPC, 32'h3100);
        chk("jr_taken", {31'd0, bus.taken}, 32'd1);

        // Registered status
        @(posedge clk); #1;
        chk("q_jr_taken", {31'd0, bus.taken_q}, 32'd1);
        chk("q_jr_last", bus.last_target_q, 32'h3100);
        drive(32'h3008, 2'd1, 3'd0, 26'd0, 16'hFFFE, 32'd0, 6'b000000);
        @(posedge clk); #1;
        chk("q_nt_taken", {31'd0, bus.taken_q}, 32'd0);
        chk("q_nt_last", bus.last_target_q, 32'h300C);

        // Reset clears status but not the combinational path
        drive(32'h3000, 2'd3, 3'd0, 26'd0, 16'd0, 32'h0000_3100, 6'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst2_taken_q", {31'd0, bus.taken_q}, 32'd0);
        chk("rst2_last", bus.last_target_q, 32'h3000);
        chk("rst2_npc", bus.NPC, 32'h3100);
        chk("rst2_taken", {31'd0, bus.taken}, 32'd1);
        reset = 1'b0;

        // Wrap
        drive(32'hFFFF_FFFC, 2'd0, 3'd0, 26'd0, 16'd0, 32'd0, 6'd0);
        chk("wrap_npc", bus.NPC, 32'h0000_0000);
        chk("wrap_pc4", bus.PC4, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
